// File: rtl/iir_ctrl.sv
// iir_ctrl: sequences samples into an external IIR filter and
// buffers its results in a small credit-protected output FIFO.
module iir_ctrl #(
   parameter int OUT_DEPTH = 4,
   parameter int FLUSH_LEN = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [9:0] out_data,
   input  logic       out_ready,
   input  logic       flush,
   output logic       busy,
   output logic [7:0] iir_x,
   output logic       iir_reset,
   input  logic [9:0] iir_y
);

   localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(OUT_DEPTH);
   localparam logic [7:0] FLEN = 8'(FLUSH_LEN);
   localparam logic [7:0] FLEN_M1 = 8'(FLUSH_LEN - 1);

   typedef enum logic [1:0] {
      INIT,
      RUN,
      FLUSH
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  init_cnt, init_cnt_nxt;
   logic [7:0]  fcnt, fcnt_nxt;
   logic        iir_reset_nxt;
   logic        pend1, pend2;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [9:0]  mem [OUT_DEPTH];
   logic [CW:0] credit;
   logic        accept, push, pop;

   // Every in-flight sample already owns a FIFO slot.
   assign credit = {1'b0, count}
                 + {{CW{1'b0}}, pend1}
                 + {{CW{1'b0}}, pend2};

   assign in_ready  = (state == RUN) && !flush && (credit < DEPTH_W);
   assign accept    = in_valid && in_ready;
   assign push      = pend2;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign busy      = (state != RUN);

   always_comb begin
      state_nxt     = state;
      init_cnt_nxt  = init_cnt;
      fcnt_nxt      = fcnt;
      iir_reset_nxt = 1'b0;
      unique case (state)
         INIT: begin
            if (init_cnt == 2'd2) begin
               state_nxt = RUN;
            end else begin
               init_cnt_nxt  = init_cnt + 2'd1;
               iir_reset_nxt = 1'b1;
            end
         end
         RUN: begin
            if (flush) begin
               state_nxt = FLUSH;
               fcnt_nxt  = '0;
            end
         end
         FLUSH: begin
            // Drain counting starts only once the pipeline is empty.
            if (fcnt == FLEN) begin
               state_nxt = RUN;
            end else if (!pend1 && !pend2) begin
               fcnt_nxt      = fcnt + 8'd1;
               iir_reset_nxt = (fcnt == FLEN_M1);
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         init_cnt  <= '0;
         fcnt      <= '0;
         pend1     <= 1'b0;
         pend2     <= 1'b0;
         iir_x     <= '0;
         iir_reset <= 1'b1;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         state     <= state_nxt;
         init_cnt  <= init_cnt_nxt;
         fcnt      <= fcnt_nxt;
         pend1     <= accept;
         pend2     <= pend1;
         iir_x     <= accept ? in_data : '0;
         iir_reset <= iir_reset_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= iir_y;
   end

endmodule
